fb_write_arbiter: RTL

Shares the single framebuffer write port between the paint datapath and the cursor and palette-cursor overlay drawers. Each requester presents one pixel write (x, y, data) under a req/ack handshake. The arbiter picks a winner by round-robin, with an optional fixed priority for the paint path. It also supports locked bursts so a cursor sprite is drawn without interleaving, and bounds each burst to prevent starvation.

---
 rtl/paint_pkg.sv | 10 +
 rtl/rr_pick.sv | 23 ++
 rtl/fb_write_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/paint_pkg.sv
// paint_pkg: shared paint-path widths, arbiter state encoding and requester indices
package paint_pkg;
    localparam int XW_DEF = 8;
    localparam int YW_DEF = 8;
    localparam int DW_DEF = 8;
    localparam int REQ_PAINT = 0;
    localparam int REQ_CURSOR = 1;
    localparam int REQ_PALETA = 2;
    typedef enum logic {ARB = 1'b0, WRITE = 1'b1} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating priority encoder; req/excl masks and last-winner ptr in, one-hot win and valid out
module rr_pick #(
    parameter int N = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic [N-1:0]  excl,
    output logic [N-1:0]  win,
    output logic          valid
);
    logic [N-1:0] m, rot, pick;
    logic [2*N-1:0] dbl, back;
    always_comb begin
        m = req & ~excl;
        dbl = {m, m} >> (int'(ptr) + 1);
        rot = dbl[N-1:0];
        pick = rot & (~rot + N'(1));
        back = {pick, pick} << (int'(ptr) + 1);
        win = back[2*N-1:N];
        valid = |m;
    end
endmodule

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin/paint-priority arbiter with locked bursts for the framebuffer write port
// ports: clk (falling edge), rst (async, active-low), req/lock per requester, req_x/req_y/req_data packed
// operands; gnt one-hot owner, ack write pulse, fb_we/fb_x/fb_y/fb_data write port, busy = lock held
module fb_write_arbiter
    import paint_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int XW = XW_DEF,
    parameter int YW = YW_DEF,
    parameter int DW = DW_DEF,
    parameter int PAINT_PRIO = 1,
    parameter int MAX_BURST = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    lock,
    input  logic [N_REQ*XW-1:0] req_x,
    input  logic [N_REQ*YW-1:0] req_y,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    ack,
    output logic                fb_we,
    output logic [XW-1:0]       fb_x,
    output logic [YW-1:0]       fb_y,
    output logic [DW-1:0]       fb_data,
    output logic                busy
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);
    arb_state_t state;
    logic [CW-1:0] cnt;
    logic [PW-1:0] rr_ptr, win_idx;
    logic [N_REQ-1:0] excl, rr_win, win;
    logic [XW-1:0] win_x;
    logic [YW-1:0] win_y;
    logic [DW-1:0] win_d;
    logic at_max, keep, win_lock, rr_vld;
    rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
        .req(req), .ptr(rr_ptr), .excl(excl), .win(rr_win), .valid(rr_vld)
    );
    // gnt is one-hot, so masking with it selects the current owner's bits
    always_comb begin
        at_max = cnt >= CW'(MAX_BURST);
        keep = busy && |(req & lock & gnt) && !at_max;
        excl = (busy && at_max && |(req & ~gnt)) ? gnt : '0;
        win = keep ? gnt
            : (PAINT_PRIO != 0 && req[REQ_PAINT] && !excl[REQ_PAINT]) ? N_REQ'(1)
            : rr_win;
        win_lock = |(lock & win);
        win_idx = '0;
        win_x = '0;
        win_y = '0;
        win_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i]) begin
                win_idx = PW'(i);
                win_x = req_x[i*XW +: XW];
                win_y = req_y[i*YW +: YW];
                win_d = req_data[i*DW +: DW];
            end
        end
    end
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state <= ARB;
            gnt <= '0;
            ack <= '0;
            fb_we <= 1'b0;
            fb_x <= '0;
            fb_y <= '0;
            fb_data <= '0;
            busy <= 1'b0;
            cnt <= '0;
            rr_ptr <= PW'(N_REQ - 1);
        end else if (state == WRITE) begin
            state <= ARB;
            fb_we <= 1'b0;
            ack <= '0;
            cnt <= at_max ? cnt : cnt + CW'(1);
        end else if (!rr_vld) begin
            gnt <= '0;
            busy <= 1'b0;
            cnt <= '0;
        end else begin
            state <= WRITE;
            fb_we <= 1'b1;
            ack <= win;
            gnt <= win;
            rr_ptr <= win_idx;
            busy <= win_lock;
            if (win != gnt) cnt <= '0;
            fb_x <= win_x;
            fb_y <= win_y;
            fb_data <= win_d;
        end
    end
endmodule
